exu_forward_ctrl_ysyx_23060136: RTL and testbench
=================================================

# exu_forward_ctrl_ysyx_23060136

Operand-forwarding and load-use stall controller for the EXU stage. It compares the EXU instruction's source indices (rs1, rs2, CSR) against in-flight producers in MEM and WB and drives the `FORWARD_*` data and hazard-select signals consumed by the EXU operand muxes. It stalls EXU while a load in MEM has not returned data. Producer results retiring during a stall are latched into per-operand holding registers so the stalled instruction never sees stale operands.

## Interface
Parameters:
- `CSR_AW`, default 12: CSR address width.
- `CNT_W`, default 32: stall-cycle counter width.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `EXU_valid`  in  1: EXU holds a valid instruction.
- `EXU_fire`  in  1: EXU instruction hands off to MEM this cycle.
- `EXU_flush`  in  1: squash the EXU instruction (redirect).
- `EXU_rs1`, `EXU_rs2`  in  5: source register indices.
- `EXU_rs1_en`, `EXU_rs2_en`, `EXU_csr_en`  in  1 each: the source is actually read.
- `EXU_csr_rs`  in  CSR_AW: source CSR address.
- `MEM_valid`, `MEM_rd_wen`, `MEM_csr_wen`, `MEM_is_load`, `MEM_load_done`  in  1 each: MEM producer status.
- `MEM_rd`  in  5: MEM destination register.
- `MEM_csr_rd`  in  CSR_AW: MEM destination CSR.
- `MEM_rd_data`, `MEM_csr_data`  in  32: MEM results. `MEM_rd_data` carries load data when `MEM_load_done`=1.
- `WB_valid`, `WB_rd_wen`, `WB_csr_wen`  in  1 each: WB producer status.
- `WB_rd`  in  5: WB destination register.
- `WB_csr_rd`  in  CSR_AW: WB destination CSR.
- `WB_rd_data`, `WB_csr_data`  in  32: WB results.
- `FORWARD_rs1_data_EXU`, `FORWARD_rs2_data_EXU`, `FORWARD_csr_rs_data_EXU`  out  32: forwarded operands.
- `FORWARD_rs1_hazard_EXU`, `FORWARD_rs2_hazard_EXU`, `FORWARD_csr_rs_hazard_EXU`  out  1: select the forwarded operand.
- `FORWARD_stall_EXU`  out  1: hold EXU and all upstream stages.
- `FORWARD_stall_cnt`  out  CNT_W: saturating count of stall cycles.

## Operation
- Match rules:
  - GPR match requires source_en, producer valid, producer wen, and equal index.
  - Index 0 never matches.
  - CSR match compares the full CSR_AW address.
- Per-operand source priority: MEM match > WB match > held register > none.
  - The hazard flag is 1 for any of the first three sources; the data output comes from the winning source.
  - With no source, the data output is 0 and the hazard flag is 0.
- MEM match on a load with `MEM_load_done`=0 is a load-use hazard:
  - `FORWARD_stall_EXU`=1 and that operand's hazard flag=0.
  - No load hazard applies to CSR operands.
- `FORWARD_stall_EXU` = `EXU_valid` & ~`EXU_flush` & (any operand in load-use hazard).
- Holding registers (`held_valid`, `held_data`, one per operand): while stall=1, any WB match on that operand latches `WB_rd_data` / `WB_csr_data` and sets valid. A later WB match overwrites the held value.
- Clearing of held registers:
  - All held valids clear on `EXU_fire` or `EXU_flush`.
  - Clear has priority over capture in the same cycle.
- FSM, 2 states:
  - IDLE→LOAD_WAIT when stall=1.
  - LOAD_WAIT→IDLE when stall=0 (load completes, or flush).
  - LOAD_WAIT with `EXU_fire`=1 is illegal; the controller ignores `EXU_fire` in that state.
- `FORWARD_stall_cnt` increments each cycle stall=1 and saturates at all-ones.

## Timing
- Data, hazard and stall outputs are combinational from the current inputs and registered state; 0-cycle latency.
- Load-use stall releases in the same cycle `MEM_load_done`=1: MEM load data is forwarded directly and EXU may fire that cycle.
- Held registers, FSM and counter update on the rising `clk`. New held data is visible the cycle after capture.
- Reset (`rst_n`=0, asynchronous):
  - State IDLE, all `held_valid`=0, `held_data`=0, counter=0.
  - While held in reset, outputs equal the combinational function of the inputs with held_valid=0.
- Reset mid-stall: state returns to IDLE and held data is discarded. Upstream flushes the pipeline on reset.
- Simultaneous MEM and WB match on the same index: MEM wins (the younger producer).

## Structure
- Shared package `ysyx_23060136_fwd_pkg`:
  - FSM state enum `fwd_state_t` {IDLE, LOAD_WAIT}.
  - Source-select enum {SRC_NONE, SRC_MEM, SRC_WB, SRC_HELD}.
  - `CSR_AW` default constant.
- Sub-module `exu_fwd_operand_ysyx_23060136`, instantiated three times (rs1, rs2, csr; the csr instance has load-hazard checking tied off). Each instance contains:
  - the match/priority logic;
  - that operand's holding register;
  - its local load-hazard output.
- Top level holds the stall OR-reduction, the FSM, the counter and the shared clear.

## Test plan
- **MEM forward:** `EXU_rs1`=5, MEM writes x5=0xDEADBEEF (not a load) → `FORWARD_rs1_hazard_EXU`=1, `FORWARD_rs1_data_EXU`=0xDEADBEEF, stall=0.
- **Priority:** MEM and WB both write x7 (0x11 / 0x22) with rs2=7 → rs2 data=0x11. Repeat with rs2=0 → hazard=0.
- **Load-use:** MEM load to x3 with `MEM_load_done`=0 for 3 cycles, then 1 with data 0xCAFE0000 → stall=1 for 3 cycles, stall_cnt=3, state back to IDLE. On the done cycle, rs1 data=0xCAFE0000 and hazard=1.
- **Held capture:** during a stall on rs1=3, WB retires x4=0x1234 with rs2=4 → the next cycle, with no WB/MEM match, rs2 hazard=1 and data=0x1234. Held clears after `EXU_fire`.
- **CSR forward:** csr_rs=0x300, WB csr write 0x300=0x1800 → csr hazard=1 and data=0x1800. csr_rs=0x301 → hazard=0.
- **Flush/reset:** assert `EXU_flush` during a stall → stall=0 immediately and held cleared. Pulse `rst_n` low mid-stall → state IDLE and counter=0 asynchronously.

Source files
------------

// File: rtl/ysyx_23060136_fwd_pkg.sv
// Shared types and constants for the EXU operand-forwarding controller.
package ysyx_23060136_fwd_pkg;

    localparam int CSR_AW_DEF = 12;

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } fwd_state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_WB,
        SRC_HELD
    } fwd_src_t;

endpackage

// File: rtl/exu_fwd_operand_ysyx_23060136.sv
// One EXU source operand: producer match, source priority, holding register
// and the local load-use hazard flag.
module exu_fwd_operand_ysyx_23060136
    import ysyx_23060136_fwd_pkg::*;
#(
    parameter int   IDX_W          = 5,
    parameter logic ZERO_IDX_VALID = 1'b0,
    parameter logic LOAD_CHK       = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_src_en,
    input  logic [IDX_W-1:0] i_src_idx,
    input  logic             i_stall,
    input  logic             i_clear,
    input  logic             i_mem_valid,
    input  logic             i_mem_wen,
    input  logic             i_mem_is_load,
    input  logic             i_mem_load_done,
    input  logic [IDX_W-1:0] i_mem_idx,
    input  logic [31:0]      i_mem_data,
    input  logic             i_wb_valid,
    input  logic             i_wb_wen,
    input  logic [IDX_W-1:0] i_wb_idx,
    input  logic [31:0]      i_wb_data,
    output logic [31:0]      o_data,
    output logic             o_hazard,
    output logic             o_load_haz
);

    logic        r_held_valid;
    logic [31:0] r_held_data;

    logic        w_idx_ok;
    logic        w_mem_match;
    logic        w_wb_match;
    logic        w_mem_pending;
    fwd_src_t    w_src;

    assign w_idx_ok      = ZERO_IDX_VALID | (i_src_idx != '0);
    assign w_mem_match   = i_src_en & w_idx_ok & i_mem_valid & i_mem_wen & (i_mem_idx == i_src_idx);
    assign w_wb_match    = i_src_en & w_idx_ok & i_wb_valid & i_wb_wen & (i_wb_idx == i_src_idx);
    assign w_mem_pending = LOAD_CHK & i_mem_is_load & ~i_mem_load_done;
    assign o_load_haz    = w_mem_match & w_mem_pending;

    always_comb begin
        w_src = SRC_NONE;
        if (w_mem_match) begin
            // An unfinished load owns the operand: nothing older may be used.
            w_src = w_mem_pending ? SRC_NONE : SRC_MEM;
        end else if (w_wb_match) begin
            w_src = SRC_WB;
        end else if (r_held_valid) begin
            w_src = SRC_HELD;
        end
    end

    always_comb begin
        o_data   = 32'h0;
        o_hazard = 1'b0;
        case (w_src)
            SRC_MEM: begin
                o_data   = i_mem_data;
                o_hazard = 1'b1;
            end
            SRC_WB: begin
                o_data   = i_wb_data;
                o_hazard = 1'b1;
            end
            SRC_HELD: begin
                o_data   = r_held_data;
                o_hazard = 1'b1;
            end
            default: begin
                o_data   = 32'h0;
                o_hazard = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held_valid <= 1'b0;
            r_held_data  <= 32'h0;
        end else if (i_clear) begin
            r_held_valid <= 1'b0;
        end else if (i_stall && w_wb_match) begin
            r_held_valid <= 1'b1;
            r_held_data  <= i_wb_data;
        end
    end

endmodule

// File: rtl/exu_forward_ctrl_ysyx_23060136.sv
// EXU forwarding controller: three operand forwarders, load-use stall,
// stall FSM and saturating stall-cycle counter.
module exu_forward_ctrl_ysyx_23060136
    import ysyx_23060136_fwd_pkg::*;
#(
    parameter int CSR_AW = CSR_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EXU_valid,
    input  logic              EXU_fire,
    input  logic              EXU_flush,
    input  logic [4:0]        EXU_rs1,
    input  logic [4:0]        EXU_rs2,
    input  logic              EXU_rs1_en,
    input  logic              EXU_rs2_en,
    input  logic              EXU_csr_en,
    input  logic [CSR_AW-1:0] EXU_csr_rs,
    input  logic              MEM_valid,
    input  logic              MEM_rd_wen,
    input  logic              MEM_csr_wen,
    input  logic              MEM_is_load,
    input  logic              MEM_load_done,
    input  logic [4:0]        MEM_rd,
    input  logic [CSR_AW-1:0] MEM_csr_rd,
    input  logic [31:0]       MEM_rd_data,
    input  logic [31:0]       MEM_csr_data,
    input  logic              WB_valid,
    input  logic              WB_rd_wen,
    input  logic              WB_csr_wen,
    input  logic [4:0]        WB_rd,
    input  logic [CSR_AW-1:0] WB_csr_rd,
    input  logic [31:0]       WB_rd_data,
    input  logic [31:0]       WB_csr_data,
    output logic [31:0]       FORWARD_rs1_data_EXU,
    output logic [31:0]       FORWARD_rs2_data_EXU,
    output logic [31:0]       FORWARD_csr_rs_data_EXU,
    output logic              FORWARD_rs1_hazard_EXU,
    output logic              FORWARD_rs2_hazard_EXU,
    output logic              FORWARD_csr_rs_hazard_EXU,
    output logic              FORWARD_stall_EXU,
    output logic [CNT_W-1:0]  FORWARD_stall_cnt
);

    // state     | meaning
    // IDLE      | no load-use stall outstanding
    // LOAD_WAIT | EXU held waiting for a MEM load to return data

    fwd_state_t       r_state;
    fwd_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_rs1_load_haz;
    logic w_rs2_load_haz;
    logic w_csr_load_haz;
    logic w_stall;
    logic w_fire_ok;
    logic w_clear;

    assign w_stall   = EXU_valid & ~EXU_flush & (w_rs1_load_haz | w_rs2_load_haz | w_csr_load_haz);
    // A fire while still stalled in LOAD_WAIT is illegal upstream and ignored.
    assign w_fire_ok = EXU_fire & ~((r_state == LOAD_WAIT) & w_stall);
    assign w_clear   = w_fire_ok | EXU_flush;

    assign FORWARD_stall_EXU = w_stall;
    assign FORWARD_stall_cnt = r_stall_cnt;

    exu_fwd_operand_ysyx_23060136 #(
        .IDX_W(5), .ZERO_IDX_VALID(1'b0), .LOAD_CHK(1'b1)
    ) u_fwd_rs1 (
        .clk(clk), .rst_n(rst_n),
        .i_src_en(EXU_rs1_en), .i_src_idx(EXU_rs1),
        .i_stall(w_stall), .i_clear(w_clear),
        .i_mem_valid(MEM_valid), .i_mem_wen(MEM_rd_wen),
        .i_mem_is_load(MEM_is_load), .i_mem_load_done(MEM_load_done),
        .i_mem_idx(MEM_rd), .i_mem_data(MEM_rd_data),
        .i_wb_valid(WB_valid), .i_wb_wen(WB_rd_wen),
        .i_wb_idx(WB_rd), .i_wb_data(WB_rd_data),
        .o_data(FORWARD_rs1_data_EXU), .o_hazard(FORWARD_rs1_hazard_EXU),
        .o_load_haz(w_rs1_load_haz)
    );

    exu_fwd_operand_ysyx_23060136 #(
        .IDX_W(5), .ZERO_IDX_VALID(1'b0), .LOAD_CHK(1'b1)
    ) u_fwd_rs2 (
        .clk(clk), .rst_n(rst_n),
        .i_src_en(EXU_rs2_en), .i_src_idx(EXU_rs2),
        .i_stall(w_stall), .i_clear(w_clear),
        .i_mem_valid(MEM_valid), .i_mem_wen(MEM_rd_wen),
        .i_mem_is_load(MEM_is_load), .i_mem_load_done(MEM_load_done),
        .i_mem_idx(MEM_rd), .i_mem_data(MEM_rd_data),
        .i_wb_valid(WB_valid), .i_wb_wen(WB_rd_wen),
        .i_wb_idx(WB_rd), .i_wb_data(WB_rd_data),
        .o_data(FORWARD_rs2_data_EXU), .o_hazard(FORWARD_rs2_hazard_EXU),
        .o_load_haz(w_rs2_load_haz)
    );

    exu_fwd_operand_ysyx_23060136 #(
        .IDX_W(CSR_AW), .ZERO_IDX_VALID(1'b1), .LOAD_CHK(1'b0)
    ) u_fwd_csr (
        .clk(clk), .rst_n(rst_n),
        .i_src_en(EXU_csr_en), .i_src_idx(EXU_csr_rs),
        .i_stall(w_stall), .i_clear(w_clear),
        .i_mem_valid(MEM_valid), .i_mem_wen(MEM_csr_wen),
        .i_mem_is_load(1'b0), .i_mem_load_done(1'b1),
        .i_mem_idx(MEM_csr_rd), .i_mem_data(MEM_csr_data),
        .i_wb_valid(WB_valid), .i_wb_wen(WB_csr_wen),
        .i_wb_idx(WB_csr_rd), .i_wb_data(WB_csr_data),
        .o_data(FORWARD_csr_rs_data_EXU), .o_hazard(FORWARD_csr_rs_hazard_EXU),
        .o_load_haz(w_csr_load_haz)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_stall)  w_state_nxt = LOAD_WAIT;
            LOAD_WAIT: if (!w_stall) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_exu_forward_ctrl_ysyx_23060136.sv
// Directed bench for the EXU forwarding controller (4-bit counter to reach saturation).
module tb_exu_forward_ctrl_ysyx_23060136;

    localparam int CSR_AW = 12;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              EXU_valid, EXU_fire, EXU_flush;
    logic [4:0]        EXU_rs1, EXU_rs2;
    logic              EXU_rs1_en, EXU_rs2_en, EXU_csr_en;
    logic [CSR_AW-1:0] EXU_csr_rs;
    logic              MEM_valid, MEM_rd_wen, MEM_csr_wen, MEM_is_load, MEM_load_done;
    logic [4:0]        MEM_rd;
    logic [CSR_AW-1:0] MEM_csr_rd;
    logic [31:0]       MEM_rd_data, MEM_csr_data;
    logic              WB_valid, WB_rd_wen, WB_csr_wen;
    logic [4:0]        WB_rd;
    logic [CSR_AW-1:0] WB_csr_rd;
    logic [31:0]       WB_rd_data, WB_csr_data;
    logic [31:0]       rs1_data, rs2_data, csr_data;
    logic              rs1_haz, rs2_haz, csr_haz, stall;
    logic [CNT_W-1:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    exu_forward_ctrl_ysyx_23060136 #(.CSR_AW(CSR_AW), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .EXU_valid(EXU_valid), .EXU_fire(EXU_fire), .EXU_flush(EXU_flush),
        .EXU_rs1(EXU_rs1), .EXU_rs2(EXU_rs2),
        .EXU_rs1_en(EXU_rs1_en), .EXU_rs2_en(EXU_rs2_en), .EXU_csr_en(EXU_csr_en),
        .EXU_csr_rs(EXU_csr_rs),
        .MEM_valid(MEM_valid), .MEM_rd_wen(MEM_rd_wen), .MEM_csr_wen(MEM_csr_wen),
        .MEM_is_load(MEM_is_load), .MEM_load_done(MEM_load_done),
        .MEM_rd(MEM_rd), .MEM_csr_rd(MEM_csr_rd),
        .MEM_rd_data(MEM_rd_data), .MEM_csr_data(MEM_csr_data),
        .WB_valid(WB_valid), .WB_rd_wen(WB_rd_wen), .WB_csr_wen(WB_csr_wen),
        .WB_rd(WB_rd), .WB_csr_rd(WB_csr_rd),
        .WB_rd_data(WB_rd_data), .WB_csr_data(WB_csr_data),
        .FORWARD_rs1_data_EXU(rs1_data), .FORWARD_rs2_data_EXU(rs2_data),
        .FORWARD_csr_rs_data_EXU(csr_data),
        .FORWARD_rs1_hazard_EXU(rs1_haz), .FORWARD_rs2_hazard_EXU(rs2_haz),
        .FORWARD_csr_rs_hazard_EXU(csr_haz),
        .FORWARD_stall_EXU(stall), .FORWARD_stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        EXU_valid = 0; EXU_fire = 0; EXU_flush = 0;
        EXU_rs1 = 0; EXU_rs2 = 0; EXU_rs1_en = 0; EXU_rs2_en = 0; EXU_csr_en = 0;
        EXU_csr_rs = 0;
        MEM_valid = 0; MEM_rd_wen = 0; MEM_csr_wen = 0; MEM_is_load = 0; MEM_load_done = 0;
        MEM_rd = 0; MEM_csr_rd = 0; MEM_rd_data = 0; MEM_csr_data = 0;
        WB_valid = 0; WB_rd_wen = 0; WB_csr_wen = 0; WB_rd = 0; WB_csr_rd = 0;
        WB_rd_data = 0; WB_csr_data = 0;
    endtask

    task automatic step();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pending_load_x3();
        EXU_valid = 1; EXU_rs1_en = 1; EXU_rs1 = 5'd3;
        MEM_valid = 1; MEM_rd_wen = 1; MEM_rd = 5'd3; MEM_is_load = 1; MEM_load_done = 0;
        MEM_rd_data = 32'hBAD0BAD0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #12;
        settle();
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_cnt", {28'h0, stall_cnt}, 32'h0);
        check("reset_rs1_haz", {31'h0, rs1_haz}, 32'h0);
        check("reset_rs1_data", rs1_data, 32'h0);
        rst_n = 1;

        // MEM ALU result forwarded to rs1
        step();
        EXU_valid = 1; EXU_rs1_en = 1; EXU_rs1 = 5'd5;
        MEM_valid = 1; MEM_rd_wen = 1; MEM_rd = 5'd5; MEM_rd_data = 32'hDEADBEEF;
        settle();
        check("mem_fwd_haz", {31'h0, rs1_haz}, 32'h1);
        check("mem_fwd_data", rs1_data, 32'hDEADBEEF);
        check("mem_fwd_stall", {31'h0, stall}, 32'h0);
        EXU_rs1_en = 0;
        settle();
        check("rs1_en_off_haz", {31'h0, rs1_haz}, 32'h0);

        // MEM beats WB on the same index; x0 never matches
        step();
        EXU_valid = 1; EXU_rs2_en = 1; EXU_rs2 = 5'd7;
        MEM_valid = 1; MEM_rd_wen = 1; MEM_rd = 5'd7; MEM_rd_data = 32'h11;
        WB_valid = 1; WB_rd_wen = 1; WB_rd = 5'd7; WB_rd_data = 32'h22;
        settle();
        check("prio_data", rs2_data, 32'h11);
        check("prio_haz", {31'h0, rs2_haz}, 32'h1);
        MEM_valid = 0;
        settle();
        check("wb_only_data", rs2_data, 32'h22);
        MEM_valid = 1; EXU_rs2 = 5'd0; MEM_rd = 5'd0; WB_rd = 5'd0;
        settle();
        check("x0_haz", {31'h0, rs2_haz}, 32'h0);
        check("x0_data", rs2_data, 32'h0);

        // Load-use stall with WB capture into the rs2 holding register
        step();
        pending_load_x3();
        EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        WB_valid = 1; WB_rd_wen = 1; WB_rd = 5'd4; WB_rd_data = 32'h1234;
        settle();
        check("lu1_stall", {31'h0, stall}, 32'h1);
        check("lu1_rs1_haz", {31'h0, rs1_haz}, 32'h0);
        check("lu1_rs1_data", rs1_data, 32'h0);
        check("lu1_rs2_data", rs2_data, 32'h1234);
        check("lu1_cnt", {28'h0, stall_cnt}, 32'h0);
        step();
        pending_load_x3();
        EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        EXU_fire = 1;
        settle();
        check("lu2_stall", {31'h0, stall}, 32'h1);
        check("lu2_held_haz", {31'h0, rs2_haz}, 32'h1);
        check("lu2_held_data", rs2_data, 32'h1234);
        check("lu2_cnt", {28'h0, stall_cnt}, 32'h1);
        step();
        pending_load_x3();
        EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        settle();
        check("lu3_held_haz", {31'h0, rs2_haz}, 32'h1);
        check("lu3_cnt", {28'h0, stall_cnt}, 32'h2);
        step();
        pending_load_x3();
        EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        MEM_load_done = 1; MEM_rd_data = 32'hCAFE0000; EXU_fire = 1;
        settle();
        check("done_stall", {31'h0, stall}, 32'h0);
        check("done_rs1_haz", {31'h0, rs1_haz}, 32'h1);
        check("done_rs1_data", rs1_data, 32'hCAFE0000);
        check("done_cnt", {28'h0, stall_cnt}, 32'h3);
        step();
        EXU_valid = 1; EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        settle();
        check("fire_clears_held", {31'h0, rs2_haz}, 32'h0);
        check("post_cnt", {28'h0, stall_cnt}, 32'h3);

        // CSR forwarding, no load hazard on CSR operands
        step();
        EXU_valid = 1; EXU_csr_en = 1; EXU_csr_rs = 12'h300;
        WB_valid = 1; WB_csr_wen = 1; WB_csr_rd = 12'h300; WB_csr_data = 32'h1800;
        settle();
        check("csr_wb_haz", {31'h0, csr_haz}, 32'h1);
        check("csr_wb_data", csr_data, 32'h1800);
        EXU_csr_rs = 12'h301;
        settle();
        check("csr_miss_haz", {31'h0, csr_haz}, 32'h0);
        EXU_csr_rs = 12'h300;
        MEM_valid = 1; MEM_csr_wen = 1; MEM_csr_rd = 12'h300; MEM_csr_data = 32'h55;
        MEM_is_load = 1; MEM_load_done = 0;
        settle();
        check("csr_mem_data", csr_data, 32'h55);
        check("csr_no_stall", {31'h0, stall}, 32'h0);

        // Stall qualifiers: x0 load and invalid EXU
        step();
        pending_load_x3();
        EXU_rs1 = 5'd0; MEM_rd = 5'd0;
        settle();
        check("x0_load_no_stall", {31'h0, stall}, 32'h0);
        EXU_rs1 = 5'd3; MEM_rd = 5'd3; EXU_valid = 0;
        settle();
        check("invalid_no_stall", {31'h0, stall}, 32'h0);

        // Flush during a stall drops stall and held data
        step();
        pending_load_x3();
        EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        WB_valid = 1; WB_rd_wen = 1; WB_rd = 5'd4; WB_rd_data = 32'hABCD;
        settle();
        check("fl_stall", {31'h0, stall}, 32'h1);
        step();
        pending_load_x3();
        EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        EXU_flush = 1;
        settle();
        check("fl_stall_drop", {31'h0, stall}, 32'h0);
        check("fl_held_data", rs2_data, 32'hABCD);
        step();
        pending_load_x3();
        EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        settle();
        check("fl_held_cleared", {31'h0, rs2_haz}, 32'h0);
        check("fl_cnt", {28'h0, stall_cnt}, 32'h4);

        // Asynchronous reset mid-stall, after capturing a held value
        WB_valid = 1; WB_rd_wen = 1; WB_rd = 5'd4; WB_rd_data = 32'h7777;
        step();
        pending_load_x3();
        EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        settle();
        check("rst_pre_held", rs2_data, 32'h7777);
        rst_n = 0;
        settle();
        check("rst_cnt_async", {28'h0, stall_cnt}, 32'h0);
        check("rst_held_gone", {31'h0, rs2_haz}, 32'h0);
        check("rst_comb_stall", {31'h0, stall}, 32'h1);
        step();
        rst_n = 1;
        EXU_valid = 1; EXU_rs2_en = 1; EXU_rs2 = 5'd4;
        settle();
        check("post_rst_haz", {31'h0, rs2_haz}, 32'h0);

        // Counter saturation over 20 stall cycles with a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step();
            pending_load_x3();
        end
        settle();
        check("sat_cnt_pre", {28'h0, stall_cnt}, 32'hF);
        step();
        settle();
        check("sat_cnt", {28'h0, stall_cnt}, 32'hF);
        check("sat_stall_off", {31'h0, stall}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
